// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the MEM stage and an external requester.
// The CPU wins by default. A starved external side gets a bounded forced burst.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WaitW  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [WaitW-1:0]  WaitLast  = WaitW'(MAX_WAIT - 1);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);

  typedef enum logic [0:0] {OwnCpu, OwnExt} state_e;

  state_e              state_q, state_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= OwnCpu;
      wait_q   <= '0;
      burst_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    unique case (state_q)
      OwnCpu: begin
        if (ext_req && cpu_req) begin
          if (wait_q == WaitLast) begin
            state_d = OwnExt;
            wait_d  = '0;
            burst_d = '0;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end else begin
          wait_d = '0;
        end
      end
      OwnExt: begin
        // In OwnExt every cycle with ext_req present is a granted beat.
        if (!ext_req || burst_q == BurstLast) begin
          state_d = OwnCpu;
          burst_d = '0;
        end else begin
          burst_d = burst_q + BurstW'(1);
        end
      end
      default: state_d = OwnCpu;
    endcase
  end

  always_comb begin
    ext_gnt   = ext_req && (state_q == OwnExt || !cpu_req);
    cpu_stall = cpu_req && ext_gnt;
    cpu_rdata = mem_rdata;
    if (ext_gnt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else begin
      mem_we    = cpu_req && cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    rvalid_d = ext_gnt && !ext_we;
    rdata_d  = rvalid_d ? mem_rdata : rdata_q;
  end

  assign ext_rvalid = rvalid_q;
  assign ext_rdata  = rdata_q;

endmodule
